// File: rtl/alu_pkg.sv
// alu_pkg: shared constants, operation enum and R-type decode for alu_arb.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam logic [6:0] OPC_RTYPE = 7'b0110011;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
    OP_XOR, OP_SRL, OP_SRA, OP_OR,  OP_AND
  } alu_op_e;

  typedef struct packed {
    alu_op_e op;
    logic    legal;
  } alu_dec_t;

  // Map an RV32I R-type funct7/funct3 pair to an operation; unknown pairs are flagged illegal.
  function automatic alu_dec_t alu_decode(input logic [6:0] funct7, input logic [2:0] funct3);
    alu_dec_t d;
    d.op    = OP_ADD;
    d.legal = 1'b1;
    case ({funct7, funct3})
      {7'b0000000, 3'b000}: d.op = OP_ADD;
      {7'b0100000, 3'b000}: d.op = OP_SUB;
      {7'b0000000, 3'b001}: d.op = OP_SLL;
      {7'b0000000, 3'b010}: d.op = OP_SLT;
      {7'b0000000, 3'b011}: d.op = OP_SLTU;
      {7'b0000000, 3'b100}: d.op = OP_XOR;
      {7'b0000000, 3'b101}: d.op = OP_SRL;
      {7'b0100000, 3'b101}: d.op = OP_SRA;
      {7'b0000000, 3'b110}: d.op = OP_OR;
      {7'b0000000, 3'b111}: d.op = OP_AND;
      default:              d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way arbiter; on contention the port that did not win last time is granted.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // One-hot grant; last_grant=1 means port 1 won last, so port 0 is favoured.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arb.sv
// alu_arb: one R-type ALU shared by two requesters behind a single result register.
// Optional feature: define ALU_ARB_RR_EN for round-robin arbitration; otherwise port 0
// has fixed priority.
module alu_arb
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [6:0]  req_opcode0,
  input  logic [6:0]  req_opcode1,
  input  logic [2:0]  req_funct3_0,
  input  logic [2:0]  req_funct3_1,
  input  logic [6:0]  req_funct7_0,
  input  logic [6:0]  req_funct7_1,
  input  logic [31:0] req_in1_0,
  input  logic [31:0] req_in1_1,
  input  logic [31:0] req_in2_0,
  input  logic [31:0] req_in2_1,
  input  logic [4:0]  req_rd0,
  input  logic [4:0]  req_rd1,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [4:0]  res_rd,
  output logic        res_id,
  output logic        res_err
);

  logic [1:0]        gnt;
  logic              last_grant;
  logic              stage_free;
  logic              accept;

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic [4:0]        rd_p1;
  logic              id_p1;
  logic              err_p1;

  logic [6:0]        opc_sel;
  logic [2:0]        f3_sel;
  logic [6:0]        f7_sel;
  logic [DATA_W-1:0] in1_sel;
  logic [DATA_W-1:0] in2_sel;
  logic [4:0]        rd_sel;
  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic [4:0]        shamt;
  alu_dec_t          dec;
  logic [DATA_W-1:0] alu_res;
  logic              alu_err;

  rr_arb2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  assign stage_free = !vld_p1 || res_ready;
  assign req_ready  = (stage_free && !rst) ? gnt : 2'b00;
  assign accept     = |req_ready;

  // Operand select follows the grant; port 0 is the default when port 1 is not granted.
  always_comb begin
    opc_sel = gnt[1] ? req_opcode1  : req_opcode0;
    f3_sel  = gnt[1] ? req_funct3_1 : req_funct3_0;
    f7_sel  = gnt[1] ? req_funct7_1 : req_funct7_0;
    in1_sel = gnt[1] ? req_in1_1    : req_in1_0;
    in2_sel = gnt[1] ? req_in2_1    : req_in2_0;
    rd_sel  = gnt[1] ? req_rd1      : req_rd0;
  end

  assign a_s   = in1_sel;
  assign b_s   = in2_sel;
  assign shamt = in2_sel[4:0];

  // R-type datapath; anything not decodable yields zero with the error flag set.
  always_comb begin
    dec     = alu_decode(f7_sel, f3_sel);
    alu_res = '0;
    alu_err = 1'b0;
    if ((opc_sel != OPC_RTYPE) || !dec.legal) begin
      alu_err = 1'b1;
    end else begin
      case (dec.op)
        OP_ADD:  alu_res = in1_sel + in2_sel;
        OP_SUB:  alu_res = in1_sel - in2_sel;
        OP_SLL:  alu_res = in1_sel << shamt;
        OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
        OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (in1_sel < in2_sel)};
        OP_XOR:  alu_res = in1_sel ^ in2_sel;
        OP_SRL:  alu_res = in1_sel >> shamt;
        OP_SRA:  alu_res = a_s >>> shamt;
        OP_OR:   alu_res = in1_sel | in2_sel;
        OP_AND:  alu_res = in1_sel & in2_sel;
        default: alu_res = '0;
      endcase
    end
  end

`ifdef ALU_ARB_RR_EN
  // Remember the winner of each accepted request so contention alternates.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= gnt[1];
    end
  end
`else
  assign last_grant = 1'b1;
`endif

  // ---- stage p1: result register, held until the consumer takes it ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      rd_p1   <= '0;
      id_p1   <= 1'b0;
      err_p1  <= 1'b0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      data_p1 <= alu_res;
      rd_p1   <= rd_sel;
      id_p1   <= gnt[1];
      err_p1  <= alu_err;
    end else if (res_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign res_valid = vld_p1;
  assign res_data  = data_p1;
  assign res_rd    = rd_p1;
  assign res_id    = id_p1;
  assign res_err   = err_p1;

endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: directed vectors with a scoreboard queue and an independent output monitor.
module tb_alu_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [6:0]  req_opcode0, req_opcode1;
  logic [2:0]  req_funct3_0, req_funct3_1;
  logic [6:0]  req_funct7_0, req_funct7_1;
  logic [31:0] req_in1_0, req_in1_1, req_in2_0, req_in2_1;
  logic [4:0]  req_rd0, req_rd1;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic        res_id;
  logic        res_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        id;
    logic        err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        err;
  } vec_t;
  vec_t vecs[13];

  localparam logic [6:0] R = 7'b0110011;

  alu_arb dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode0(req_opcode0), .req_opcode1(req_opcode1),
    .req_funct3_0(req_funct3_0), .req_funct3_1(req_funct3_1),
    .req_funct7_0(req_funct7_0), .req_funct7_1(req_funct7_1),
    .req_in1_0(req_in1_0), .req_in1_1(req_in1_1),
    .req_in2_0(req_in2_0), .req_in2_1(req_in2_1),
    .req_rd0(req_rd0), .req_rd1(req_rd1),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_rd(res_rd), .res_id(res_id), .res_err(res_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Monitor: every transferred result must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result actual data=%h rd=%0d id=%0d err=%0d required none",
                 res_data, res_rd, res_id, res_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (res_data !== e.data || res_rd !== e.rd || res_id !== e.id || res_err !== e.err) begin
          failures++;
          $display("FAIL result actual data=%h rd=%0d id=%0d err=%0d required data=%h rd=%0d id=%0d err=%0d",
                   res_data, res_rd, res_id, res_err, e.data, e.rd, e.id, e.err);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    if (p == 0) begin
      req_opcode0 = opc; req_funct3_0 = f3; req_funct7_0 = f7;
      req_in1_0 = a; req_in2_0 = b; req_rd0 = rd; req_valid[0] = 1'b1;
    end else begin
      req_opcode1 = opc; req_funct3_1 = f3; req_funct7_1 = f7;
      req_in1_1 = a; req_in2_1 = b; req_rd1 = rd; req_valid[1] = 1'b1;
    end
  endtask

  task automatic issue(input int p, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input logic err);
    bit ok;
    ok = 1'b0;
    drive(p, opc, f3, f7, a, b, rd);
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (req_ready[p]) begin
        ok = 1'b1;
        sb.push_back(exp_t'{exp, rd, p[0], err});
      end
      tick();
    end
    req_valid[p] = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout port=%0d actual=not_accepted required=accepted", p);
    end
  endtask

  initial begin
    logic lg;
    int   g;

    vecs[0]  = '{R, 3'b000, 7'b0000000, 32'd5,         32'd7,         32'd12,        1'b0};
    vecs[1]  = '{R, 3'b000, 7'b0100000, 32'd5,         32'd7,         32'hFFFFFFFE,  1'b0};
    vecs[2]  = '{R, 3'b001, 7'b0000000, 32'd1,         32'h21,        32'd2,         1'b0};
    vecs[3]  = '{R, 3'b010, 7'b0000000, 32'hFFFFFFFF,  32'd1,         32'd1,         1'b0};
    vecs[4]  = '{R, 3'b011, 7'b0000000, 32'd1,         32'hFFFFFFFF,  32'd1,         1'b0};
    vecs[5]  = '{R, 3'b100, 7'b0000000, 32'hF0F0F0F0,  32'hFFFF0000,  32'h0F0FF0F0,  1'b0};
    vecs[6]  = '{R, 3'b101, 7'b0000000, 32'h80000000,  32'd4,         32'h08000000,  1'b0};
    vecs[7]  = '{R, 3'b101, 7'b0100000, 32'h80000000,  32'h24,        32'hF8000000,  1'b0};
    vecs[8]  = '{R, 3'b110, 7'b0000000, 32'h00FF0000,  32'h000000FF,  32'h00FF00FF,  1'b0};
    vecs[9]  = '{R, 3'b111, 7'b0000000, 32'h12345678,  32'h0000FFFF,  32'h00005678,  1'b0};
    vecs[10] = '{7'b0010011, 3'b000, 7'b0000000, 32'd3, 32'd4,        32'd0,         1'b1};
    vecs[11] = '{R, 3'b001, 7'b0100000, 32'd3,         32'd4,         32'd0,         1'b1};
    vecs[12] = '{R, 3'b000, 7'b0000000, 32'hFFFFFFFF,  32'd1,         32'd0,         1'b0};

    rst = 1'b1; res_ready = 1'b1; req_valid = 2'b11;
    req_opcode0 = '0; req_opcode1 = '0; req_funct3_0 = '0; req_funct3_1 = '0;
    req_funct7_0 = '0; req_funct7_1 = '0; req_in1_0 = '0; req_in1_1 = '0;
    req_in2_0 = '0; req_in2_1 = '0; req_rd0 = '0; req_rd1 = '0;

    // Reset: no ready while in reset even with both requests up; outputs cleared.
    repeat (2) begin
      @(negedge clk);
      chk("reset_req_ready", {30'd0, req_ready}, 32'd0);
      tick();
    end
    @(negedge clk);
    chk("reset_res_valid", {31'd0, res_valid}, 32'd0);
    chk("reset_res_fields", {res_data[25:0], res_rd, res_id}, 32'd0);
    chk("reset_res_err", {31'd0, res_err}, 32'd0);
    tick();
    req_valid = 2'b00;
    rst = 1'b0;

    // Contention for four cycles.
    drive(0, R, 3'b000, 7'b0000000, 32'd1, 32'd2, 5'd1);
    drive(1, R, 3'b000, 7'b0100000, 32'd10, 32'd3, 5'd2);
    lg = 1'b1;
    for (int c = 0; c < 4; c++) begin
      g = lg ? 0 : 1;
      @(negedge clk);
      chk("contention_grant", {30'd0, req_ready}, (g == 0) ? 32'd1 : 32'd2);
      if (g == 0) sb.push_back(exp_t'{32'd3, 5'd1, 1'b0, 1'b0});
      else        sb.push_back(exp_t'{32'd7, 5'd2, 1'b1, 1'b0});
`ifdef ALU_ARB_RR_EN
      lg = g[0];
`endif
      tick();
    end
    req_valid = 2'b00;
    tick();

    // Directed operations, alternating ports.
    for (int i = 0; i < 13; i++) begin
      issue(i % 2, vecs[i].opc, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b,
            5'(i + 3), vecs[i].exp, vecs[i].err);
    end
    repeat (2) tick();

    // Backpressure: result held, nothing accepted, then drain and accept same cycle.
    res_ready = 1'b0;
    issue(0, R, 3'b000, 7'b0000000, 32'h0000DE00, 32'h000000AD, 5'd7, 32'h0000DEAD, 1'b0);
    drive(1, R, 3'b100, 7'b0000000, 32'd3, 32'd5, 5'd9);
    repeat (3) begin
      @(negedge clk);
      chk("hold_res_valid", {31'd0, res_valid}, 32'd1);
      chk("hold_res_data", res_data, 32'h0000DEAD);
      chk("hold_req_ready", {30'd0, req_ready}, 32'd0);
      tick();
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("drain_accept_same_cycle", {30'd0, req_ready}, 32'd2);
    if (req_ready[1]) sb.push_back(exp_t'{32'd6, 5'd9, 1'b1, 1'b0});
    tick();
    req_valid = 2'b00;
    repeat (2) tick();

    // Reset while a result is pending discards it; first contention afterwards goes to port 0.
    res_ready = 1'b0;
    issue(1, R, 3'b000, 7'b0000000, 32'd1, 32'd1, 5'd4, 32'd2, 1'b0);
    rst = 1'b1;
    sb.delete();
    tick();
    @(negedge clk);
    chk("midreset_res_valid", {31'd0, res_valid}, 32'd0);
    chk("midreset_req_ready", {30'd0, req_ready}, 32'd0);
    tick();
    rst = 1'b0;
    res_ready = 1'b1;
    drive(0, R, 3'b110, 7'b0000000, 32'h0000000C, 32'h00000003, 5'd11);
    drive(1, R, 3'b000, 7'b0000000, 32'd8, 32'd8, 5'd12);
    @(negedge clk);
    chk("post_reset_grant", {30'd0, req_ready}, 32'd1);
    if (req_ready[0]) sb.push_back(exp_t'{32'h0000000F, 5'd11, 1'b0, 1'b0});
    tick();
    req_valid = 2'b00;
    repeat (3) tick();

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
